// File: rtl/softreg_router_if.sv
`default_nettype none
// ============================================================================
// Module      : softreg_router_if
// Description : SoftReg channel bundle (request + read response) carrying N
//               parallel lanes. The master issues requests and accepts
//               responses; the slave grants requests and returns responses.
// Revision    : 1.0 - initial release
// ============================================================================
interface softreg_router_if #(
  parameter int N = 1
);
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_is_write;
  logic [N-1:0][31:0] req_addr;
  logic [N-1:0][63:0] req_data;
  logic [N-1:0]       req_grant;
  logic [N-1:0]       resp_valid;
  logic [N-1:0][63:0] resp_data;
  logic [N-1:0]       resp_grant;

  modport master (
    output req_valid, req_is_write, req_addr, req_data, resp_grant,
    input  req_grant, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_is_write, req_addr, req_data, resp_grant,
    output req_grant, resp_valid, resp_data
  );
endinterface
`default_nettype wire

// File: rtl/softreg_router.sv
`default_nettype none
// ============================================================================
// Module      : softreg_router
// Description : Fans one SoftReg request stream out to NUM_APPS app ports by
//               an address select field and returns read responses upstream
//               strictly in request order via an order FIFO and a one-entry
//               output register. Reads to missing apps return ERR_DATA.
// Revision    : 1.0 - initial release
// ============================================================================
module softreg_router #(
  parameter int          NUM_APPS        = 4,
  parameter int          SEL_LSB         = 12,
  parameter int          SEL_W           = (NUM_APPS > 1) ? $clog2(NUM_APPS) : 1,
  parameter int          LOG_ORDER_DEPTH = 4,
  parameter logic [63:0] ERR_DATA        = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  softreg_router_if.slave             softreg,
  softreg_router_if.master            app_softreg,
  output logic [LOG_ORDER_DEPTH:0]    rd_outstanding_o
);

  localparam int          DEPTH    = 1 << LOG_ORDER_DEPTH;
  localparam logic [31:0] SEL_MASK = 32'(((64'd1 << SEL_W) - 64'd1) << SEL_LSB);

  // One order FIFO entry: err=1 means answer with ERR_DATA, else wait on app.
  typedef struct packed {
    logic             err;
    logic [SEL_W-1:0] app;
  } order_t;

  logic [SEL_W-1:0]         w_sel;
  logic                     w_in_range;
  logic                     w_rd_ok;
  logic                     w_tgt_grant;
  logic                     w_req_grant;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_ld_ok;
  logic                     w_head_vld;
  logic [63:0]              w_head_data;
  logic                     w_order_full;
  logic                     w_order_empty;
  order_t                   w_head;

  order_t                   r_mem_q [DEPTH];
  logic [LOG_ORDER_DEPTH-1:0] r_wr_ptr_q;
  logic [LOG_ORDER_DEPTH-1:0] r_rd_ptr_q;
  logic [LOG_ORDER_DEPTH:0] r_count_q, r_count_d;
  logic                     r_obuf_vld_q, r_obuf_vld_d;
  logic [63:0]              r_obuf_data_q, r_obuf_data_d;

  assign w_order_full  = (r_count_q == (LOG_ORDER_DEPTH+1)'(DEPTH));
  assign w_order_empty = (r_count_q == '0);
  assign w_head        = r_mem_q[r_rd_ptr_q];
  assign w_ld_ok       = !r_obuf_vld_q || softreg.resp_grant[0];

  // Request path: decode the select field, fan out to apps, form upstream grant.
  always_comb begin
    w_sel       = softreg.req_addr[0][SEL_LSB +: SEL_W];
    w_in_range  = (32'(w_sel) < 32'(NUM_APPS));
    // A full order FIFO blocks every read, even if it pops this cycle.
    w_rd_ok     = softreg.req_is_write[0] || !w_order_full;
    w_tgt_grant = 1'b0;
    for (int i = 0; i < NUM_APPS; i++) begin
      app_softreg.req_valid[i]    = softreg.req_valid[0] && w_in_range && w_rd_ok &&
                                    (w_sel == SEL_W'(i));
      app_softreg.req_is_write[i] = softreg.req_is_write[0];
      app_softreg.req_addr[i]     = softreg.req_addr[0] & ~SEL_MASK;
      app_softreg.req_data[i]     = softreg.req_data[0];
      if (w_sel == SEL_W'(i)) begin
        w_tgt_grant = app_softreg.req_grant[i];
      end
    end
    // Out-of-range writes are swallowed; out-of-range reads need only FIFO room.
    w_req_grant = softreg.req_valid[0] && w_rd_ok && (!w_in_range || w_tgt_grant);
    w_push      = w_req_grant && !softreg.req_is_write[0];
  end

  assign softreg.req_grant[0] = w_req_grant;

  // Response path: only the FIFO head app may be granted, and only if obuf can load.
  always_comb begin
    w_head_vld  = 1'b0;
    w_head_data = ERR_DATA;
    for (int i = 0; i < NUM_APPS; i++) begin
      app_softreg.resp_grant[i] = 1'b0;
      if (!w_head.err && (w_head.app == SEL_W'(i))) begin
        w_head_vld                = app_softreg.resp_valid[i];
        w_head_data               = app_softreg.resp_data[i];
        app_softreg.resp_grant[i] = app_softreg.resp_valid[i] && !w_order_empty && w_ld_ok;
      end
    end
    w_pop         = !w_order_empty && w_ld_ok && (w_head.err || w_head_vld);
    r_obuf_vld_d  = r_obuf_vld_q && !softreg.resp_grant[0];
    r_obuf_data_d = r_obuf_data_q;
    if (w_pop) begin
      r_obuf_vld_d  = 1'b1;
      r_obuf_data_d = w_head_data;
    end
    r_count_d = r_count_q + (LOG_ORDER_DEPTH+1)'(w_push) - (LOG_ORDER_DEPTH+1)'(w_pop);
  end

  // Order FIFO storage; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_q[r_wr_ptr_q] <= '{err: !w_in_range, app: w_sel};
    end
  end

  // Pointers, occupancy and output register; reset discards all outstanding reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr_q    <= '0;
      r_rd_ptr_q    <= '0;
      r_count_q     <= '0;
      r_obuf_vld_q  <= 1'b0;
      r_obuf_data_q <= '0;
    end else begin
      if (w_push) r_wr_ptr_q <= r_wr_ptr_q + 1'b1;
      if (w_pop)  r_rd_ptr_q <= r_rd_ptr_q + 1'b1;
      r_count_q     <= r_count_d;
      r_obuf_vld_q  <= r_obuf_vld_d;
      r_obuf_data_q <= r_obuf_data_d;
    end
  end

  assign softreg.resp_valid[0] = r_obuf_vld_q;
  assign softreg.resp_data[0]  = r_obuf_data_q;
  assign rd_outstanding_o      = r_count_q;

endmodule
`default_nettype wire

// File: tb/tb_softreg_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_softreg_router
// Description : Directed self-checking bench. DUT A: 4 apps, 4-deep order
//               FIFO. DUT B: 3 apps, default depth (out-of-range app 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_softreg_router;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  softreg_router_if #(.N(1)) ua ();
  softreg_router_if #(.N(4)) aa ();
  softreg_router_if #(.N(1)) ub ();
  softreg_router_if #(.N(3)) ab ();
  logic [2:0] rd_a;
  logic [4:0] rd_b;

  softreg_router #(.NUM_APPS(4), .LOG_ORDER_DEPTH(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .softreg(ua.slave), .app_softreg(aa.master),
    .rd_outstanding_o(rd_a)
  );

  softreg_router #(.NUM_APPS(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .softreg(ub.slave), .app_softreg(ab.master),
    .rd_outstanding_o(rd_b)
  );

  task automatic up_a(input logic v, input logic wr, input logic [31:0] a, input logic [63:0] d);
    ua.req_valid[0] = v; ua.req_is_write[0] = wr; ua.req_addr[0] = a; ua.req_data[0] = d;
  endtask

  task automatic up_b(input logic v, input logic wr, input logic [31:0] a, input logic [63:0] d);
    ub.req_valid[0] = v; ub.req_is_write[0] = wr; ub.req_addr[0] = a; ub.req_data[0] = d;
  endtask

  task automatic test_reset;
    aa.resp_valid = 4'b1111;
    #12;
    n_checks++; if (ua.resp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got=%b exp=0", ua.resp_valid[0]); end
    n_checks++; if (ua.resp_data[0] !== 64'd0) begin n_fail++; $display("FAIL rst_resp_data got=%h exp=0", ua.resp_data[0]); end
    n_checks++; if (rd_a !== 3'd0) begin n_fail++; $display("FAIL rst_rd_outstanding got=%0d exp=0", rd_a); end
    n_checks++; if (aa.resp_grant !== 4'b0000) begin n_fail++; $display("FAIL rst_app_resp_grant got=%b exp=0000", aa.resp_grant); end
    n_checks++; if (rd_b !== 5'd0) begin n_fail++; $display("FAIL rst_rd_outstanding_b got=%0d exp=0", rd_b); end
    @(negedge clk);
    rst_n = 1'b1;
    aa.resp_valid = 4'b0000;
  endtask

  task automatic test_write_route;
    @(negedge clk);
    up_a(1'b1, 1'b1, 32'h0000_2010, 64'h1122_3344_5566_7788);
    aa.req_grant = 4'b0100;
    #1;
    n_checks++; if (aa.req_valid !== 4'b0100) begin n_fail++; $display("FAIL wr_app_valid got=%b exp=0100", aa.req_valid); end
    n_checks++; if (aa.req_addr[2] !== 32'h0000_0010) begin n_fail++; $display("FAIL wr_app_addr got=%h exp=00000010", aa.req_addr[2]); end
    n_checks++; if (aa.req_data[2] !== 64'h1122_3344_5566_7788) begin n_fail++; $display("FAIL wr_app_data got=%h exp=1122334455667788", aa.req_data[2]); end
    n_checks++; if (aa.req_is_write[2] !== 1'b1) begin n_fail++; $display("FAIL wr_app_iswrite got=%b exp=1", aa.req_is_write[2]); end
    n_checks++; if (ua.req_grant[0] !== 1'b1) begin n_fail++; $display("FAIL wr_grant got=%b exp=1", ua.req_grant[0]); end
    aa.req_grant = 4'b1011;
    #1;
    n_checks++; if (ua.req_grant[0] !== 1'b0) begin n_fail++; $display("FAIL wr_grant_app_busy got=%b exp=0", ua.req_grant[0]); end
    @(negedge clk);
    up_a(1'b0, 1'b0, 32'h0, 64'h0);
    aa.req_grant = 4'b1111;
    #1;
    n_checks++; if (rd_a !== 3'd0) begin n_fail++; $display("FAIL wr_no_push got=%0d exp=0", rd_a); end
  endtask

  task automatic test_order;
    ua.resp_grant[0] = 1'b1;
    @(negedge clk);
    up_a(1'b1, 1'b0, 32'h0000_1000, 64'h0);
    #1;
    n_checks++; if (aa.req_valid !== 4'b0010) begin n_fail++; $display("FAIL ord_rd1_valid got=%b exp=0010", aa.req_valid); end
    n_checks++; if (ua.req_grant[0] !== 1'b1) begin n_fail++; $display("FAIL ord_rd1_grant got=%b exp=1", ua.req_grant[0]); end
    @(negedge clk);
    up_a(1'b1, 1'b0, 32'h0000_0000, 64'h0);
    #1;
    n_checks++; if (ua.req_grant[0] !== 1'b1) begin n_fail++; $display("FAIL ord_rd0_grant got=%b exp=1", ua.req_grant[0]); end
    @(negedge clk);
    up_a(1'b0, 1'b0, 32'h0, 64'h0);
    aa.resp_valid = 4'b0001; aa.resp_data[0] = 64'hA;
    #1;
    n_checks++; if (rd_a !== 3'd2) begin n_fail++; $display("FAIL ord_outstanding got=%0d exp=2", rd_a); end
    n_checks++; if (aa.resp_grant !== 4'b0000) begin n_fail++; $display("FAIL ord_app0_held got=%b exp=0000", aa.resp_grant); end
    @(negedge clk);
    #1;
    n_checks++; if (aa.resp_grant !== 4'b0000) begin n_fail++; $display("FAIL ord_app0_held2 got=%b exp=0000", aa.resp_grant); end
    n_checks++; if (ua.resp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL ord_no_resp got=%b exp=0", ua.resp_valid[0]); end
    @(negedge clk);
    aa.resp_valid = 4'b0011; aa.resp_data[1] = 64'hB;
    #1;
    n_checks++; if (aa.resp_grant !== 4'b0010) begin n_fail++; $display("FAIL ord_app1_grant got=%b exp=0010", aa.resp_grant); end
    @(negedge clk);
    aa.resp_valid = 4'b0001;
    #1;
    n_checks++; if (ua.resp_valid[0] !== 1'b1 || ua.resp_data[0] !== 64'hB) begin n_fail++; $display("FAIL ord_first_resp got=%b/%h exp=1/b", ua.resp_valid[0], ua.resp_data[0]); end
    n_checks++; if (aa.resp_grant !== 4'b0001) begin n_fail++; $display("FAIL ord_app0_grant got=%b exp=0001", aa.resp_grant); end
    @(negedge clk);
    aa.resp_valid = 4'b0000;
    #1;
    n_checks++; if (ua.resp_data[0] !== 64'hA) begin n_fail++; $display("FAIL ord_second_resp got=%h exp=a", ua.resp_data[0]); end
    n_checks++; if (rd_a !== 3'd0) begin n_fail++; $display("FAIL ord_drained got=%0d exp=0", rd_a); end
    @(negedge clk);
    #1;
    n_checks++; if (ua.resp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL ord_obuf_empty got=%b exp=0", ua.resp_valid[0]); end
  endtask

  task automatic test_full;
    ua.resp_grant[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      up_a(1'b1, 1'b0, 32'(i) << 12, 64'h0);
      #1;
      n_checks++; if (ua.req_grant[0] !== 1'b1) begin n_fail++; $display("FAIL full_fill_grant%0d got=%b exp=1", i, ua.req_grant[0]); end
    end
    @(negedge clk);
    up_a(1'b1, 1'b0, 32'h0000_0000, 64'h0);
    #1;
    n_checks++; if (rd_a !== 3'd4) begin n_fail++; $display("FAIL full_count got=%0d exp=4", rd_a); end
    n_checks++; if (ua.req_grant[0] !== 1'b0) begin n_fail++; $display("FAIL full_rd_blocked got=%b exp=0", ua.req_grant[0]); end
    n_checks++; if (aa.req_valid !== 4'b0000) begin n_fail++; $display("FAIL full_rd_app_valid got=%b exp=0000", aa.req_valid); end
    @(negedge clk);
    up_a(1'b1, 1'b1, 32'h0000_1040, 64'h77);
    #1;
    n_checks++; if (ua.req_grant[0] !== 1'b1) begin n_fail++; $display("FAIL full_wr_grant got=%b exp=1", ua.req_grant[0]); end
    n_checks++; if (aa.req_valid !== 4'b0010) begin n_fail++; $display("FAIL full_wr_app_valid got=%b exp=0010", aa.req_valid); end
    @(negedge clk);
    up_a(1'b1, 1'b0, 32'h0000_0000, 64'h0);
    ua.resp_grant[0] = 1'b1;
    aa.resp_valid = 4'b0001; aa.resp_data[0] = 64'h100;
    #1;
    n_checks++; if (ua.req_grant[0] !== 1'b0) begin n_fail++; $display("FAIL full_rd_blocked_on_pop got=%b exp=0", ua.req_grant[0]); end
    n_checks++; if (aa.resp_grant !== 4'b0001) begin n_fail++; $display("FAIL full_pop_grant got=%b exp=0001", aa.resp_grant); end
    @(negedge clk);
    aa.resp_valid = 4'b0000;
    ua.resp_grant[0] = 1'b0;
    #1;
    n_checks++; if (rd_a !== 3'd3) begin n_fail++; $display("FAIL full_after_pop got=%0d exp=3", rd_a); end
    n_checks++; if (ua.req_grant[0] !== 1'b1) begin n_fail++; $display("FAIL full_rd5_grant got=%b exp=1", ua.req_grant[0]); end
    n_checks++; if (ua.resp_valid[0] !== 1'b1 || ua.resp_data[0] !== 64'h100) begin n_fail++; $display("FAIL full_pop_data got=%b/%h exp=1/100", ua.resp_valid[0], ua.resp_data[0]); end
  endtask

  task automatic test_backpressure;
    logic [63:0] exp_d [4];
    logic [3:0]  exp_g [4];
    exp_d = '{64'hD1, 64'hD2, 64'hD3, 64'hD0};
    exp_g = '{4'b0100, 4'b1000, 4'b0001, 4'b0000};
    @(negedge clk);
    up_a(1'b0, 1'b0, 32'h0, 64'h0);
    aa.resp_valid = 4'b1111;
    for (int i = 0; i < 4; i++) aa.resp_data[i] = 64'hD0 + 64'(i);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (aa.resp_grant !== 4'b0000) begin n_fail++; $display("FAIL bp_app_grant%0d got=%b exp=0000", k, aa.resp_grant); end
      n_checks++; if (ua.resp_valid[0] !== 1'b1 || ua.resp_data[0] !== 64'h100) begin n_fail++; $display("FAIL bp_obuf_stable%0d got=%b/%h exp=1/100", k, ua.resp_valid[0], ua.resp_data[0]); end
      @(negedge clk);
    end
    ua.resp_grant[0] = 1'b1;
    #1;
    n_checks++; if (aa.resp_grant !== 4'b0010) begin n_fail++; $display("FAIL bp_release_grant got=%b exp=0010", aa.resp_grant); end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      #1;
      n_checks++; if (ua.resp_valid[0] !== 1'b1 || ua.resp_data[0] !== exp_d[j]) begin n_fail++; $display("FAIL bp_stream%0d got=%b/%h exp=1/%h", j, ua.resp_valid[0], ua.resp_data[0], exp_d[j]); end
      n_checks++; if (aa.resp_grant !== exp_g[j]) begin n_fail++; $display("FAIL bp_next_grant%0d got=%b exp=%b", j, aa.resp_grant, exp_g[j]); end
    end
    aa.resp_valid = 4'b0000;
    @(negedge clk);
    #1;
    n_checks++; if (ua.resp_valid[0] !== 1'b0 || rd_a !== 3'd0) begin n_fail++; $display("FAIL bp_drained got=%b/%0d exp=0/0", ua.resp_valid[0], rd_a); end
  endtask

  task automatic test_oor;
    ab.req_grant = 3'b111;
    @(negedge clk);
    up_b(1'b1, 1'b0, 32'h0000_0000, 64'h0);
    #1;
    n_checks++; if (ub.req_grant[0] !== 1'b1) begin n_fail++; $display("FAIL oor_rd0a_grant got=%b exp=1", ub.req_grant[0]); end
    @(negedge clk);
    up_b(1'b1, 1'b0, 32'h0000_3000, 64'h0);
    #1;
    n_checks++; if (ub.req_grant[0] !== 1'b1) begin n_fail++; $display("FAIL oor_rd_grant got=%b exp=1", ub.req_grant[0]); end
    n_checks++; if (ab.req_valid !== 3'b000) begin n_fail++; $display("FAIL oor_rd_app_valid got=%b exp=000", ab.req_valid); end
    @(negedge clk);
    up_b(1'b1, 1'b0, 32'h0000_0000, 64'h0);
    #1;
    n_checks++; if (ub.req_grant[0] !== 1'b1) begin n_fail++; $display("FAIL oor_rd0b_grant got=%b exp=1", ub.req_grant[0]); end
    @(negedge clk);
    up_b(1'b1, 1'b1, 32'h0000_3000, 64'h99);
    #1;
    n_checks++; if (ub.req_grant[0] !== 1'b1) begin n_fail++; $display("FAIL oor_wr_grant got=%b exp=1", ub.req_grant[0]); end
    n_checks++; if (ab.req_valid !== 3'b000) begin n_fail++; $display("FAIL oor_wr_app_valid got=%b exp=000", ab.req_valid); end
    @(negedge clk);
    up_b(1'b0, 1'b0, 32'h0, 64'h0);
    ub.resp_grant[0] = 1'b1;
    ab.resp_valid = 3'b001; ab.resp_data[0] = 64'h55;
    #1;
    n_checks++; if (rd_b !== 5'd3) begin n_fail++; $display("FAIL oor_count got=%0d exp=3", rd_b); end
    n_checks++; if (ab.resp_grant !== 3'b001) begin n_fail++; $display("FAIL oor_app0a_grant got=%b exp=001", ab.resp_grant); end
    @(negedge clk);
    ab.resp_data[0] = 64'h66;
    #1;
    n_checks++; if (ub.resp_data[0] !== 64'h55) begin n_fail++; $display("FAIL oor_resp1 got=%h exp=55", ub.resp_data[0]); end
    n_checks++; if (ab.resp_grant !== 3'b000) begin n_fail++; $display("FAIL oor_err_no_grant got=%b exp=000", ab.resp_grant); end
    @(negedge clk);
    #1;
    n_checks++; if (ub.resp_data[0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL oor_resp_err got=%h exp=ffffffffffffffff", ub.resp_data[0]); end
    n_checks++; if (ab.resp_grant !== 3'b001) begin n_fail++; $display("FAIL oor_app0b_grant got=%b exp=001", ab.resp_grant); end
    @(negedge clk);
    ab.resp_valid = 3'b000;
    #1;
    n_checks++; if (ub.resp_valid[0] !== 1'b1 || ub.resp_data[0] !== 64'h66) begin n_fail++; $display("FAIL oor_resp3 got=%b/%h exp=1/66", ub.resp_valid[0], ub.resp_data[0]); end
    n_checks++; if (rd_b !== 5'd0) begin n_fail++; $display("FAIL oor_drained got=%0d exp=0", rd_b); end
  endtask

  task automatic test_reset_mid;
    ua.resp_grant[0] = 1'b0;
    @(negedge clk); up_a(1'b1, 1'b0, 32'h0000_2000, 64'h0);
    @(negedge clk); up_a(1'b1, 1'b0, 32'h0000_0000, 64'h0);
    @(negedge clk); up_a(1'b1, 1'b0, 32'h0000_1000, 64'h0);
    @(negedge clk);
    up_a(1'b0, 1'b0, 32'h0, 64'h0);
    aa.resp_valid = 4'b0100; aa.resp_data[2] = 64'hC;
    #1;
    n_checks++; if (aa.resp_grant !== 4'b0100) begin n_fail++; $display("FAIL rm_app2_grant got=%b exp=0100", aa.resp_grant); end
    @(negedge clk);
    aa.resp_valid = 4'b0001; aa.resp_data[0] = 64'hE;
    #1;
    n_checks++; if (ua.resp_valid[0] !== 1'b1 || rd_a !== 3'd2) begin n_fail++; $display("FAIL rm_pre_state got=%b/%0d exp=1/2", ua.resp_valid[0], rd_a); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (ua.resp_valid[0] !== 1'b0 || ua.resp_data[0] !== 64'd0) begin n_fail++; $display("FAIL rm_resp_cleared got=%b/%h exp=0/0", ua.resp_valid[0], ua.resp_data[0]); end
    n_checks++; if (rd_a !== 3'd0) begin n_fail++; $display("FAIL rm_outstanding got=%0d exp=0", rd_a); end
    n_checks++; if (aa.resp_grant !== 4'b0000) begin n_fail++; $display("FAIL rm_no_grant got=%b exp=0000", aa.resp_grant); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (aa.resp_grant !== 4'b0000) begin n_fail++; $display("FAIL rm_post_no_grant got=%b exp=0000", aa.resp_grant); end
    aa.resp_valid = 4'b0000;
  endtask

  initial begin
    ua.req_valid = '0; ua.req_is_write = '0; ua.req_addr = '0; ua.req_data = '0; ua.resp_grant = '0;
    ub.req_valid = '0; ub.req_is_write = '0; ub.req_addr = '0; ub.req_data = '0; ub.resp_grant = '0;
    aa.req_grant = '0; aa.resp_valid = '0; aa.resp_data = '0;
    ab.req_grant = '0; ab.resp_valid = '0; ab.resp_data = '0;
    test_reset;
    test_write_route;
    test_order;
    test_full;
    test_backpressure;
    test_oor;
    test_reset_mid;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
